// File: rtl/access_anomaly_detector.sv
// Access-stream monitor: flags out-of-range user IDs and same-user bursts,
// queues timestamped alerts in a small FIFO and keeps saturating access totals.
module access_anomaly_detector #(
    parameter int unsigned MAX_USER_ID   = 9,
    parameter int unsigned REPEAT_THRESH = 8,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_valid,
    input  logic [3:0]  user_id,
    input  logic [3:0]  resource_id,
    input  logic        alert_ready,
    output logic        alert_valid,
    output logic [1:0]  alert_code,
    output logic [3:0]  alert_user,
    output logic [3:0]  alert_resource,
    output logic [15:0] alert_time,
    output logic        overflow,
    output logic [15:0] access_count,
    output logic [15:0] invalid_count
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  MAX_ID = (MAX_USER_ID > 15) ? 5'd15 : 5'(MAX_USER_ID);
    localparam logic [3:0]  THR    = 4'(REPEAT_THRESH);
    localparam logic [3:0]  THR_M1 = 4'(REPEAT_THRESH - 1);
    localparam logic [AW:0] FULL   = (AW + 1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]  code;
        logic [3:0]  user;
        logic [3:0]  res;
        logic [15:0] ts;
    } entry_t;

    entry_t        r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_alert_valid, r_overflow;
    logic [15:0]   r_ts, r_access_count, r_invalid_count;
    logic [3:0]    r_last_user, r_run_len;
    logic          r_have_last;

    logic          w_inv, w_same, w_burst, w_push, w_pop, w_full, w_wr, w_drop;
    logic [AW:0]   w_count_nxt;
    entry_t        w_entry;

    always_comb begin
        w_inv   = access_valid && ({1'b0, user_id} > MAX_ID);
        w_same  = r_have_last && (user_id == r_last_user);
        // Fires only on the THRESH-1 -> THRESH step; saturation keeps it one-shot per run.
        w_burst = access_valid && w_same && (r_run_len == THR_M1);
        w_push  = w_inv || w_burst;
        w_pop   = r_alert_valid && alert_ready;
        w_full  = (r_count == FULL);
        w_wr    = w_push && (!w_full || w_pop);
        w_drop  = w_push && w_full && !w_pop;
        w_entry = '{code: {w_burst, w_inv}, user: user_id, res: resource_id, ts: r_ts};
        w_count_nxt = r_count;
        if (w_wr && !w_pop)
            w_count_nxt = r_count + (AW + 1)'(1);
        else if (!w_wr && w_pop)
            w_count_nxt = r_count - (AW + 1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_alert_valid   <= 1'b0;
            r_overflow      <= 1'b0;
            r_ts            <= '0;
            r_access_count  <= '0;
            r_invalid_count <= '0;
            r_last_user     <= '0;
            r_run_len       <= '0;
            r_have_last     <= 1'b0;
        end else begin
            r_ts <= r_ts + 16'd1;
            if (access_valid) begin
                if (r_access_count != '1)
                    r_access_count <= r_access_count + 16'd1;
                if (w_inv && (r_invalid_count != '1))
                    r_invalid_count <= r_invalid_count + 16'd1;
                if (w_same) begin
                    if (r_run_len != THR)
                        r_run_len <= r_run_len + 4'd1;
                end else begin
                    r_run_len   <= 4'd1;
                    r_last_user <= user_id;
                    r_have_last <= 1'b1;
                end
            end
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_drop)
                r_overflow <= 1'b1;
            r_count       <= w_count_nxt;
            r_alert_valid <= (w_count_nxt != '0);
        end
    end

    assign alert_valid    = r_alert_valid;
    assign alert_code     = r_mem[r_rd_ptr].code;
    assign alert_user     = r_mem[r_rd_ptr].user;
    assign alert_resource = r_mem[r_rd_ptr].res;
    assign alert_time     = r_mem[r_rd_ptr].ts;
    assign overflow       = r_overflow;
    assign access_count   = r_access_count;
    assign invalid_count  = r_invalid_count;

endmodule

// File: tb/tb_access_anomaly_detector.sv
// Directed bench for access_anomaly_detector: reset, burst, invalid-ID,
// combined, FIFO-full boundary, idle-gap burst and mid-run reset scenarios.
module tb_access_anomaly_detector;

    logic        clk = 1'b0;
    logic        rst;
    logic        access_valid;
    logic [3:0]  user_id;
    logic [3:0]  resource_id;
    logic        alert_ready;
    logic        alert_valid;
    logic [1:0]  alert_code;
    logic [3:0]  alert_user;
    logic [3:0]  alert_resource;
    logic [15:0] alert_time;
    logic        overflow;
    logic [15:0] access_count;
    logic [15:0] invalid_count;

    int n_vec = 0;
    int n_err = 0;

    access_anomaly_detector #(
        .MAX_USER_ID  (9),
        .REPEAT_THRESH(8),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .access_valid  (access_valid),
        .user_id       (user_id),
        .resource_id   (resource_id),
        .alert_ready   (alert_ready),
        .alert_valid   (alert_valid),
        .alert_code    (alert_code),
        .alert_user    (alert_user),
        .alert_resource(alert_resource),
        .alert_time    (alert_time),
        .overflow      (overflow),
        .access_count  (access_count),
        .invalid_count (invalid_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] u, input logic [3:0] r, input logic rdy);
        access_valid = v;
        user_id      = u;
        resource_id  = r;
        alert_ready  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [1:0] c, input logic [3:0] u,
                            input logic [3:0] r, input logic [15:0] t);
        chk({tag, "_valid"}, 32'(alert_valid), 32'd1);
        if (alert_valid) begin
            chk({tag, "_code"}, 32'(alert_code), 32'(c));
            chk({tag, "_user"}, 32'(alert_user), 32'(u));
            chk({tag, "_res"},  32'(alert_resource), 32'(r));
            chk({tag, "_time"}, 32'(alert_time), 32'(t));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(alert_valid), 32'd0);
        chk({tag, "_ovf"},   32'(overflow), 32'd0);
        chk({tag, "_acc"},   32'(access_count), 32'd0);
        chk({tag, "_inv"},   32'(invalid_count), 32'd0);
        chk({tag, "_code"},  32'(alert_code), 32'd0);
        chk({tag, "_user"},  32'(alert_user), 32'd0);
        chk({tag, "_res"},   32'(alert_resource), 32'd0);
        chk({tag, "_time"},  32'(alert_time), 32'd0);
    endtask

    // Called at posedge+1; asserts reset between edges and releases before the next edge.
    task automatic async_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_all_zero(tag);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; access_valid = 1'b0; user_id = '0; resource_id = '0; alert_ready = 1'b0;
        #12;
        chk_all_zero("por");
        #10;
        rst = 1'b0;

        // Burst: user 4 for 25 cycles starting at timestamp 0, consumer ready.
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 4'd4, 4'(i), 1'b1);
            if (i == 7) chk_head("burst", 2'b10, 4'd4, 4'd7, 16'd7);
            else        chk("burst_novalid", 32'(alert_valid), 32'd0);
        end
        chk("burst_acc", 32'(access_count), 32'd25);
        chk("burst_inv", 32'(invalid_count), 32'd0);

        // Invalid IDs 10..15 with consumer stalled; timestamps 25..30.
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 4'(10 + j), 4'(j), 1'b0);
            chk("inv_valid", 32'(alert_valid), 32'd1);
            chk("inv_ovf", 32'(overflow), (j >= 4) ? 32'd1 : 32'd0);
        end
        chk("inv_cnt", 32'(invalid_count), 32'd6);
        chk("inv_acc", 32'(access_count), 32'd31);
        for (int k = 0; k < 4; k++) begin
            chk_head("drain", 2'b01, 4'(10 + k), 4'(k), 16'(25 + k));
            step(1'b0, 4'd0, 4'd0, 1'b1);
        end
        chk("drain_empty", 32'(alert_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Combined: user 12 nine times, ready high; timestamps 35..43.
        for (int k = 0; k < 9; k++) begin
            step(1'b1, 4'd12, 4'(k), 1'b1);
            chk_head("comb", (k == 7) ? 2'b11 : 2'b01, 4'd12, 4'(k), 16'(35 + k));
        end
        step(1'b0, 4'd0, 4'd0, 1'b1);
        chk("comb_empty", 32'(alert_valid), 32'd0);
        chk("comb_inv", 32'(invalid_count), 32'd15);

        async_reset("rst1");

        // Full boundary: fill 4 entries (t=0..3), then push+pop together at t=4.
        for (int j = 0; j < 4; j++)
            step(1'b1, 4'(10 + j), 4'(j), 1'b0);
        chk("full_ovf0", 32'(overflow), 32'd0);
        step(1'b1, 4'd14, 4'd4, 1'b1);
        chk("full_pp_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk_head("full_drain", 2'b01, 4'(11 + k), 4'(1 + k), 16'(1 + k));
            step(1'b0, 4'd0, 4'd0, 1'b1);
        end
        chk("full_empty", 32'(alert_valid), 32'd0);
        chk("full_ovf1", 32'(overflow), 32'd0);

        // Idle gaps inside a user-4 run (t=9..19); burst on the 8th access at t=19.
        for (int a = 0; a < 8; a++) begin
            step(1'b1, 4'd4, 4'(a), 1'b1);
            if (a == 7) chk_head("gap_burst", 2'b10, 4'd4, 4'd7, 16'd19);
            else        chk("gap_novalid", 32'(alert_valid), 32'd0);
            if ((a % 2 == 1) && (a < 7)) begin
                step(1'b0, 4'd0, 4'd0, 1'b1);
                chk("gap_idle", 32'(alert_valid), 32'd0);
            end
        end
        step(1'b0, 4'd0, 4'd0, 1'b1);
        chk("gap_empty", 32'(alert_valid), 32'd0);

        // Mid-operation reset: 3 alerts queued and a user-4 run of 4 in progress.
        step(1'b1, 4'd10, 4'd0, 1'b0);
        step(1'b1, 4'd11, 4'd0, 1'b0);
        step(1'b1, 4'd12, 4'd0, 1'b0);
        for (int k = 0; k < 4; k++)
            step(1'b1, 4'd4, 4'd1, 1'b0);
        chk("mid_queued", 32'(alert_valid), 32'd1);
        async_reset("rst2");
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 4'd4, 4'd2, 1'b1);
            chk("mid_norun", 32'(alert_valid), 32'd0);
        end
        chk("mid_acc", 32'(access_count), 32'd7);
        step(1'b1, 4'd4, 4'd5, 1'b1);
        chk_head("mid_burst", 2'b10, 4'd4, 4'd5, 16'd7);
        chk("mid_inv", 32'(invalid_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
